l2_lookup_ctrl: RTL and testbench
=================================

// Module: l2_lookup_ctrl
// PURPOSE
//  Sequences one L2 set lookup: accepts a (set, tag) request, drives the set read and rd_mem_en
//  that load the per-way read buffers, then compares the buffered tags/states.
//  Registers hit way, first empty way and chosen victim way, and returns them on a valid/ready response.
//  Sits directly downstream of the per-way read buffers and feeds the L2 request/eviction FSM.
// PARAMETERS
//  L2_WAYS     8   ways per set; power of 2, >=2
//  WAY_BITS    3   log2(L2_WAYS)
//  TAG_BITS    20  tag width
//  SET_BITS    8   set index width
//  STATE_BITS  3   coherence state width
//  INVALID     0   state encoding meaning "way empty"
// PORTS
//  clk            in   1                    clock
//  rst            in   1                    reset
//  req_valid      in   1                    lookup request valid
//  req_ready      out  1                    block can accept request
//  req_set        in   SET_BITS             set index to look up
//  req_tag        in   TAG_BITS             tag to match
//  rd_mem_en      out  1                    read-enable to set arrays and per-way buffers
//  rd_set         out  SET_BITS             set index presented to arrays
//  tags_buf       in   L2_WAYS x TAG_BITS   buffered tags, valid the cycle after rd_mem_en
//  states_buf     in   L2_WAYS x STATE_BITS buffered states, same timing
//  evict_way_buf  in   WAY_BITS             buffered replacement way, same timing
//  resp_valid     out  1                    lookup result valid
//  resp_ready     in   1                    consumer accepts result
//  resp_hit       out  1                    tag matched a non-INVALID way
//  resp_hit_way   out  WAY_BITS             matching way (0 if no hit)
//  resp_empty     out  1                    at least one INVALID way
//  resp_empty_way out  WAY_BITS             lowest-index INVALID way (0 if none)
//  resp_way       out  WAY_BITS             chosen way: hit ? hit_way : empty ? empty_way : evict_way_buf
//  resp_state     out  STATE_BITS           states_buf[resp_way] at compare time
// BEHAVIOUR
//  Reset: rst, asynchronous, active-low; clock clk; all regs cleared, state IDLE, resp_* = 0.
//  FSM IDLE -> READ -> CMP -> RESP -> IDLE.
//  - IDLE: req_ready=1. On req_valid: latch set/tag, go READ. No other state asserts req_ready.
//  - READ (1 cycle): rd_mem_en=1, rd_set=latched set; go CMP. rd_mem_en=0 in all other states.
//  - CMP (1 cycle): buffers now hold the set. Compare combinationally, register all resp_*
//    fields, go RESP. rd_set holds the latched set from READ through RESP.
//  - RESP: resp_valid=1; all resp_* fields stable until handshake. resp_valid&resp_ready -> IDLE.
//  Hit: tags_buf[i]==tag && states_buf[i]!=INVALID; several matches -> lowest i wins.
//  Empty: states_buf[i]==INVALID; lowest i wins. A hit takes priority over empty for resp_way.
//  Latency: accept at cycle N -> resp_valid from cycle N+3. Max throughput 1 lookup per 4 cycles.
//  req_valid while busy: ignored (req_ready=0); requester must hold it.
//  resp_ready high before resp_valid: no effect.
//  Reset mid-operation: abort immediately, resp_valid drops, no partial result is retained.
// TESTING
//  1. Reset, then req set=0x12 tag=0xABCDE; way5 tag match, state=2, others INVALID
//     -> rd_mem_en high for 1 cycle with rd_set=0x12; resp at +3: hit=1, hit_way=5, way=5,
//     state=2, empty=1, empty_way=0.
//  2. Miss; ways 0-2 valid, ways 3 and 6 INVALID -> hit=0, empty=1, empty_way=3, way=3.
//  3. Miss, all ways valid, evict_way_buf=6 -> hit=0, empty=0, way=6, state=states_buf[6].
//  4. Tag matches INVALID way 1 and valid way 4 -> hit_way=4, empty_way=1, way=4.
//  5. Stall: resp_ready=0 for 5 cycles while new req_valid is held -> outputs stable,
//     req_ready=0; after handshake, IDLE accepts the pending request on the next cycle.
//  6. Assert rst while in CMP -> resp_valid=0, req_ready=1 after release, no stale response.

Source files
------------

// File: rtl/l2_lookup_ctrl.sv
// L2 set lookup sequencer: reads one set into the per-way buffers, compares the
// buffered tags/states against the request tag and returns hit/empty/victim ways.
module l2_lookup_ctrl #(
   parameter int                    L2_WAYS    = 8,
   parameter int                    WAY_BITS   = 3,
   parameter int                    TAG_BITS   = 20,
   parameter int                    SET_BITS   = 8,
   parameter int                    STATE_BITS = 3,
   parameter logic [STATE_BITS-1:0] INVALID    = '0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  req_valid,
   output logic                                  req_ready,
   input  logic [SET_BITS-1:0]                   req_set,
   input  logic [TAG_BITS-1:0]                   req_tag,
   output logic                                  rd_mem_en,
   output logic [SET_BITS-1:0]                   rd_set,
   input  logic [L2_WAYS-1:0][TAG_BITS-1:0]      tags_buf,
   input  logic [L2_WAYS-1:0][STATE_BITS-1:0]    states_buf,
   input  logic [WAY_BITS-1:0]                   evict_way_buf,
   output logic                                  resp_valid,
   input  logic                                  resp_ready,
   output logic                                  resp_hit,
   output logic [WAY_BITS-1:0]                   resp_hit_way,
   output logic                                  resp_empty,
   output logic [WAY_BITS-1:0]                   resp_empty_way,
   output logic [WAY_BITS-1:0]                   resp_way,
   output logic [STATE_BITS-1:0]                 resp_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      CMP  = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [SET_BITS-1:0] set_q;
   logic [TAG_BITS-1:0] tag_q;
   logic                accept;
   logic                capture;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      rd_mem_en  = 1'b0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               state_d = READ;
            end
         end
         READ: begin
            rd_mem_en = 1'b1;
            state_d   = CMP;
         end
         CMP: begin
            capture = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rd_set = set_q;

   logic                  hit_c, empty_c;
   logic [WAY_BITS-1:0]   hit_way_c, empty_way_c, way_c;

   // NOTE: blocking '=' here models combinational priority; the first match found in ascending order sticks.
   always_comb begin
      hit_c       = 1'b0;
      hit_way_c   = '0;
      empty_c     = 1'b0;
      empty_way_c = '0;
      for (int i = 0; i < L2_WAYS; i++) begin
         if (!hit_c && states_buf[i] != INVALID && tags_buf[i] == tag_q) begin
            hit_c     = 1'b1;
            hit_way_c = WAY_BITS'(i);
         end
         if (!empty_c && states_buf[i] == INVALID) begin
            empty_c     = 1'b1;
            empty_way_c = WAY_BITS'(i);
         end
      end
      way_c = hit_c ? hit_way_c : (empty_c ? empty_way_c : evict_way_buf);
   end

   // NOTE: sequential state uses '<=' so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         set_q          <= '0;
         tag_q          <= '0;
         resp_hit       <= 1'b0;
         resp_hit_way   <= '0;
         resp_empty     <= 1'b0;
         resp_empty_way <= '0;
         resp_way       <= '0;
         resp_state     <= '0;
      end else begin
         if (accept) begin
            set_q <= req_set;
            tag_q <= req_tag;
         end
         // Result fields only change in CMP, so they stay stable through the RESP stall.
         if (capture) begin
            resp_hit       <= hit_c;
            resp_hit_way   <= hit_way_c;
            resp_empty     <= empty_c;
            resp_empty_way <= empty_way_c;
            resp_way       <= way_c;
            resp_state     <= states_buf[way_c];
         end
      end
   end

endmodule

// File: tb/tb_l2_lookup_ctrl.sv
// Self-checking bench for l2_lookup_ctrl: a set-array memory plus read-buffer model
// upstream, directed scenarios, then randomized lookups against a reference model.
module tb_l2_lookup_ctrl;
   localparam int L2_WAYS    = 8;
   localparam int WAY_BITS   = 3;
   localparam int TAG_BITS   = 20;
   localparam int SET_BITS   = 8;
   localparam int STATE_BITS = 3;
   localparam int NSETS      = 1 << SET_BITS;

   typedef struct {
      logic                  hit;
      logic [WAY_BITS-1:0]   hit_way;
      logic                  empty;
      logic [WAY_BITS-1:0]   empty_way;
      logic [WAY_BITS-1:0]   way;
      logic [STATE_BITS-1:0] state;
   } exp_t;

   logic                               clk = 1'b0;
   logic                               rst;
   logic                               req_valid;
   logic                               req_ready;
   logic [SET_BITS-1:0]                req_set;
   logic [TAG_BITS-1:0]                req_tag;
   logic                               rd_mem_en;
   logic [SET_BITS-1:0]                rd_set;
   logic [L2_WAYS-1:0][TAG_BITS-1:0]   tags_buf;
   logic [L2_WAYS-1:0][STATE_BITS-1:0] states_buf;
   logic [WAY_BITS-1:0]                evict_way_buf;
   logic                               resp_valid;
   logic                               resp_ready;
   logic                               resp_hit;
   logic [WAY_BITS-1:0]                resp_hit_way;
   logic                               resp_empty;
   logic [WAY_BITS-1:0]                resp_empty_way;
   logic [WAY_BITS-1:0]                resp_way;
   logic [STATE_BITS-1:0]              resp_state;

   logic [TAG_BITS-1:0]   tag_mem   [NSETS][L2_WAYS];
   logic [STATE_BITS-1:0] state_mem [NSETS][L2_WAYS];
   logic [WAY_BITS-1:0]   evict_mem [NSETS];

   int   checks   = 0;
   int   failures = 0;
   exp_t cur;

   l2_lookup_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_set        (req_set),
      .req_tag        (req_tag),
      .rd_mem_en      (rd_mem_en),
      .rd_set         (rd_set),
      .tags_buf       (tags_buf),
      .states_buf     (states_buf),
      .evict_way_buf  (evict_way_buf),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_hit       (resp_hit),
      .resp_hit_way   (resp_hit_way),
      .resp_empty     (resp_empty),
      .resp_empty_way (resp_empty_way),
      .resp_way       (resp_way),
      .resp_state     (resp_state)
   );

   always #5 clk = ~clk;

   // Upstream set arrays feeding the per-way read buffers: loaded on rd_mem_en.
   always @(posedge clk) begin
      if (rd_mem_en) begin
         for (int i = 0; i < L2_WAYS; i++) begin
            tags_buf[i]   <= tag_mem[rd_set][i];
            states_buf[i] <= state_mem[rd_set][i];
         end
         evict_way_buf <= evict_mem[rd_set];
      end
   end

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Reference: scan the stored set from the top down so the lowest index is the last writer.
   function automatic exp_t model(input logic [SET_BITS-1:0] s, input logic [TAG_BITS-1:0] t);
      exp_t e;
      e.hit = 1'b0; e.hit_way = '0; e.empty = 1'b0; e.empty_way = '0;
      for (int i = L2_WAYS - 1; i >= 0; i--) begin
         if (state_mem[s][i] != 0 && tag_mem[s][i] == t) begin
            e.hit = 1'b1; e.hit_way = WAY_BITS'(i);
         end
         if (state_mem[s][i] == 0) begin
            e.empty = 1'b1; e.empty_way = WAY_BITS'(i);
         end
      end
      if (e.hit)        e.way = e.hit_way;
      else if (e.empty) e.way = e.empty_way;
      else              e.way = evict_mem[s];
      e.state = state_mem[s][e.way];
      return e;
   endfunction

   task automatic check_resp(input string tag);
      check({tag, "_hit"},       32'(resp_hit),       32'(cur.hit));
      check({tag, "_hit_way"},   32'(resp_hit_way),   32'(cur.hit_way));
      check({tag, "_empty"},     32'(resp_empty),     32'(cur.empty));
      check({tag, "_empty_way"}, 32'(resp_empty_way), 32'(cur.empty_way));
      check({tag, "_way"},       32'(resp_way),       32'(cur.way));
      check({tag, "_state"},     32'(resp_state),     32'(cur.state));
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the first RESP cycle.
   task automatic issue(input logic [SET_BITS-1:0] s, input logic [TAG_BITS-1:0] t);
      req_valid = 1'b1; req_set = s; req_tag = t;
      #1 check("idle_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("read_rd_mem_en", 32'(rd_mem_en), 32'd1);
      check("read_rd_set", 32'(rd_set), 32'(s));
      check("read_req_ready", 32'(req_ready), 32'd0);
      check("read_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      check("cmp_rd_mem_en", 32'(rd_mem_en), 32'd0);
      check("cmp_rd_set", 32'(rd_set), 32'(s));
      check("cmp_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      cur = model(s, t);
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_rd_set", 32'(rd_set), 32'(s));
      check_resp("resp");
   endtask

   // Holds RESP for 'stall' cycles (optionally with a new request pending), then handshakes.
   task automatic finish_resp(input int stall, input bit hold,
                              input logic [SET_BITS-1:0] ns, input logic [TAG_BITS-1:0] nt);
      logic [SET_BITS-1:0] s;
      s = rd_set;
      if (stall > 0) resp_ready = 1'b0;
      if (hold) begin
         req_valid = 1'b1; req_set = ns; req_tag = nt;
      end
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         check("stall_resp_valid", 32'(resp_valid), 32'd1);
         check("stall_req_ready", 32'(req_ready), 32'd0);
         check("stall_rd_mem_en", 32'(rd_mem_en), 32'd0);
         check("stall_rd_set", 32'(rd_set), 32'(s));
         check_resp("stall");
      end
      resp_ready = 1'b1;
      @(negedge clk);
      check("post_resp_valid", 32'(resp_valid), 32'd0);
      check("post_req_ready", 32'(req_ready), 32'd1);
      resp_ready = 1'b0;
   endtask

   task automatic rand_set(input logic [SET_BITS-1:0] s, input logic [TAG_BITS-1:0] t);
      int mode;
      mode = int'($urandom_range(3));
      evict_mem[s] = WAY_BITS'($urandom_range(L2_WAYS - 1));
      for (int w = 0; w < L2_WAYS; w++) begin
         if (mode != 0 && $urandom_range(3) == 0) state_mem[s][w] = '0;
         else                                     state_mem[s][w] = STATE_BITS'($urandom_range(7, 1));
         tag_mem[s][w] = ($urandom_range(3) == 0) ? t : TAG_BITS'($urandom);
      end
   endtask

   initial begin
      rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; req_set = '0; req_tag = '0;
      for (int s = 0; s < NSETS; s++) rand_set(SET_BITS'(s), TAG_BITS'($urandom));

      repeat (2) @(negedge clk);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rd_mem_en", 32'(rd_mem_en), 32'd0);
      check("rst_resp_hit", 32'(resp_hit), 32'd0);
      check("rst_resp_way", 32'(resp_way), 32'd0);
      check("rst_resp_state", 32'(resp_state), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Single hit in way 5, everything else empty.
      for (int w = 0; w < L2_WAYS; w++) begin
         tag_mem[8'h12][w] = 20'h0; state_mem[8'h12][w] = 3'd0;
      end
      tag_mem[8'h12][5] = 20'hABCDE; state_mem[8'h12][5] = 3'd2; evict_mem[8'h12] = 3'd7;
      issue(8'h12, 20'hABCDE);
      check("t1_hit_way", 32'(resp_hit_way), 32'd5);
      check("t1_state", 32'(resp_state), 32'd2);
      check("t1_empty_way", 32'(resp_empty_way), 32'd0);
      finish_resp(0, 1'b0, '0, '0);

      // Miss with ways 3 and 6 empty.
      for (int w = 0; w < L2_WAYS; w++) begin
         tag_mem[8'h34][w] = 20'h10 + 20'(w); state_mem[8'h34][w] = 3'd1;
      end
      state_mem[8'h34][3] = 3'd0; state_mem[8'h34][6] = 3'd0;
      issue(8'h34, 20'h11111);
      check("t2_way", 32'(resp_way), 32'd3);
      check("t2_hit", 32'(resp_hit), 32'd0);
      finish_resp(0, 1'b0, '0, '0);

      // Miss with a full set: victim comes from evict_way_buf.
      for (int w = 0; w < L2_WAYS; w++) begin
         tag_mem[8'h56][w] = 20'h200 + 20'(w); state_mem[8'h56][w] = 3'(1 + w % 7);
      end
      evict_mem[8'h56] = 3'd6;
      issue(8'h56, 20'h22222);
      check("t3_way", 32'(resp_way), 32'd6);
      check("t3_empty", 32'(resp_empty), 32'd0);
      check("t3_state", 32'(resp_state), 32'(state_mem[8'h56][6]));
      finish_resp(0, 1'b0, '0, '0);

      // Tag present in an INVALID way 1 and a valid way 4.
      for (int w = 0; w < L2_WAYS; w++) begin
         tag_mem[8'h78][w] = 20'h300 + 20'(w); state_mem[8'h78][w] = 3'd1;
      end
      tag_mem[8'h78][1] = 20'h33333; state_mem[8'h78][1] = 3'd0;
      tag_mem[8'h78][4] = 20'h33333; state_mem[8'h78][4] = 3'd3;
      issue(8'h78, 20'h33333);
      check("t4_hit_way", 32'(resp_hit_way), 32'd4);
      check("t4_empty_way", 32'(resp_empty_way), 32'd1);
      check("t4_way", 32'(resp_way), 32'd4);
      finish_resp(0, 1'b0, '0, '0);

      // Five-cycle stall with the next request held; it is accepted right after the handshake.
      rand_set(8'h9A, 20'h44444);
      issue(8'h34, 20'h00013);
      finish_resp(5, 1'b1, 8'h9A, 20'h44444);
      issue(8'h9A, 20'h44444);
      finish_resp(0, 1'b0, '0, '0);

      // resp_ready already high before the lookup starts.
      resp_ready = 1'b1;
      issue(8'h56, 20'h00203);
      @(negedge clk);
      check("early_ready_resp_valid", 32'(resp_valid), 32'd0);
      check("early_ready_req_ready", 32'(req_ready), 32'd1);
      resp_ready = 1'b0;

      // Reset while in CMP after a hitting lookup: nothing stale may survive.
      issue(8'h12, 20'hABCDE);
      finish_resp(0, 1'b0, '0, '0);
      req_valid = 1'b1; req_set = 8'h12; req_tag = 20'hABCDE;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_resp_valid", 32'(resp_valid), 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      check("midrst_rd_mem_en", 32'(rd_mem_en), 32'd0);
      check("midrst_resp_hit", 32'(resp_hit), 32'd0);
      check("midrst_resp_way", 32'(resp_way), 32'd0);
      check("midrst_resp_state", 32'(resp_state), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("postrst_resp_valid", 32'(resp_valid), 32'd0);
         check("postrst_req_ready", 32'(req_ready), 32'd1);
         check("postrst_rd_mem_en", 32'(rd_mem_en), 32'd0);
      end

      // Randomized lookups against the reference model.
      for (int n = 0; n < 40; n++) begin
         logic [SET_BITS-1:0] s;
         logic [TAG_BITS-1:0] t;
         bit                  early;
         s = SET_BITS'($urandom);
         t = TAG_BITS'($urandom);
         rand_set(s, t);
         early = 1'($urandom_range(1));
         resp_ready = early;
         issue(s, t);
         finish_resp(early ? 0 : int'($urandom_range(3)), 1'b0, '0, '0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
